sqrt_operand_dispatcher: RTL and testbench

// - Upstream front-end for the iterative non-restoring square-root unit: buffers radicands from a

---
 rtl/sqrt_operand_dispatcher_if.sv | 46 ++++
 rtl/sqrt_operand_dispatcher.sv | 153 +++++++++++++++
 tb/tb_sqrt_operand_dispatcher.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sqrt_operand_dispatcher_if.sv
// Bundle of the dispatcher's handshake and data buses.
//   upstream  : valid_i / ready_o / radicand_i (+ tag_i)
//   sqrt core : sqrt_valid_o / sqrt_radicand_o out, sqrt_done_i / sqrt_root_i / sqrt_rem_i in
//   result    : result_valid_o / result_ready_i / root_o / remainder_o (+ tag_o)
//   status    : busy_o
// Optional macro SQRT_DISPATCH_TAG_EN adds the 4-bit tag_i / tag_o pair.
// slave modport = dispatcher view, master modport = environment view.
interface sqrt_operand_dispatcher_if #(
  parameter int DATA_WIDTH = 32
);
  logic                    valid_i;
  logic                    ready_o;
  logic [DATA_WIDTH-1:0]   radicand_i;
  logic                    sqrt_valid_o;
  logic [DATA_WIDTH-1:0]   sqrt_radicand_o;
  logic                    sqrt_done_i;
  logic [DATA_WIDTH/2-1:0] sqrt_root_i;
  logic [DATA_WIDTH/2:0]   sqrt_rem_i;
  logic                    result_valid_o;
  logic                    result_ready_i;
  logic [DATA_WIDTH/2-1:0] root_o;
  logic [DATA_WIDTH/2:0]   remainder_o;
  logic                    busy_o;
`ifdef SQRT_DISPATCH_TAG_EN
  logic [3:0]              tag_i;
  logic [3:0]              tag_o;

  modport slave (
    input  valid_i, radicand_i, tag_i, sqrt_done_i, sqrt_root_i, sqrt_rem_i, result_ready_i,
    output ready_o, sqrt_valid_o, sqrt_radicand_o, result_valid_o, root_o, remainder_o, tag_o, busy_o
  );
  modport master (
    output valid_i, radicand_i, tag_i, sqrt_done_i, sqrt_root_i, sqrt_rem_i, result_ready_i,
    input  ready_o, sqrt_valid_o, sqrt_radicand_o, result_valid_o, root_o, remainder_o, tag_o, busy_o
  );
`else
  modport slave (
    input  valid_i, radicand_i, sqrt_done_i, sqrt_root_i, sqrt_rem_i, result_ready_i,
    output ready_o, sqrt_valid_o, sqrt_radicand_o, result_valid_o, root_o, remainder_o, busy_o
  );
  modport master (
    output valid_i, radicand_i, sqrt_done_i, sqrt_root_i, sqrt_rem_i, result_ready_i,
    input  ready_o, sqrt_valid_o, sqrt_radicand_o, result_valid_o, root_o, remainder_o, busy_o
  );
`endif
endinterface

// File: rtl/sqrt_operand_dispatcher.sv
// Front-end for a multi-cycle, non-pipelined square-root core. Radicands from a
// valid/ready producer are buffered in a FIFO and issued one at a time; the core's
// root/remainder is captured into a single-entry valid/ready output register.
// Ports:
//   clk_i     rising-edge clock
//   rst_n_i   asynchronous active-low reset
//   clk_en_i  clock enable; every state update is gated by it (also drives the core)
//   bus       sqrt_operand_dispatcher_if.slave (upstream, core and result buses, busy_o)
// Optional macro SQRT_DISPATCH_TAG_EN: carries a 4-bit tag from tag_i through the
// FIFO and the in-flight operation to tag_o alongside the result.
module sqrt_operand_dispatcher #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         clk_en_i,
  sqrt_operand_dispatcher_if.slave     bus
);
  localparam int RW = DATA_WIDTH / 2;
  localparam int MW = RW + 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] opnd_q, opnd_d;
  logic                  res_vld_q, res_vld_d;
  logic [RW-1:0]         root_q, root_d;
  logic [MW-1:0]         rem_q, rem_d;
  logic                  full, empty, push, pop, capture, res_take, sqrt_vld;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);

  // ready_o looks only at registered pointers, so a pop never frees space the same cycle.
  assign push     = clk_en_i & bus.valid_i & ~full;
  // Issue is held off while a result is still waiting downstream.
  assign pop      = clk_en_i & (state_q == S_IDLE) & ~empty & ~res_vld_q;
  assign capture  = clk_en_i & (state_q == S_WAIT) & bus.sqrt_done_i;
  assign res_take = clk_en_i & res_vld_q & bus.result_ready_i;

  // FSM: state register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (clk_en_i) begin
      unique case (state_q)
        S_IDLE:  if (!empty && !res_vld_q) state_d = S_ISSUE;
        S_ISSUE: state_d = S_WAIT;
        S_WAIT:  if (bus.sqrt_done_i) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    sqrt_vld = 1'b0;
    if (state_q == S_ISSUE) sqrt_vld = 1'b1;
  end

  // Datapath next-state
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    opnd_d    = opnd_q;
    res_vld_d = res_vld_q;
    root_d    = root_q;
    rem_d     = rem_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      opnd_d   = mem_q[rd_ptr_q[AW-1:0]];
    end
    // capture and res_take never coincide: WAIT implies no result is pending.
    if (capture) begin
      res_vld_d = 1'b1;
      root_d    = bus.sqrt_root_i;
      rem_d     = bus.sqrt_rem_i;
    end else if (res_take) begin
      res_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      opnd_q    <= '0;
      res_vld_q <= 1'b0;
      root_q    <= '0;
      rem_q     <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      opnd_q    <= opnd_d;
      res_vld_q <= res_vld_d;
      root_q    <= root_d;
      rem_q     <= rem_d;
    end
  end

  // Storage array needs no reset; pointers define its valid contents.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= bus.radicand_i;
  end

`ifdef SQRT_DISPATCH_TAG_EN
  logic [3:0] tag_mem_q [FIFO_DEPTH];
  logic [3:0] tag_hold_q, tag_hold_d, tag_q, tag_d;

  always_comb begin
    tag_hold_d = tag_hold_q;
    tag_d      = tag_q;
    if (pop)     tag_hold_d = tag_mem_q[rd_ptr_q[AW-1:0]];
    if (capture) tag_d      = tag_hold_q;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tag_hold_q <= '0;
      tag_q      <= '0;
    end else begin
      tag_hold_q <= tag_hold_d;
      tag_q      <= tag_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) tag_mem_q[wr_ptr_q[AW-1:0]] <= bus.tag_i;
  end

  assign bus.tag_o = tag_q;
`endif

  assign bus.ready_o         = ~full;
  assign bus.sqrt_valid_o    = sqrt_vld;
  assign bus.sqrt_radicand_o = opnd_q;
  assign bus.result_valid_o  = res_vld_q;
  assign bus.root_o          = root_q;
  assign bus.remainder_o     = rem_q;
  assign bus.busy_o          = (state_q != S_IDLE) | ~empty | res_vld_q;
endmodule

// File: tb/tb_sqrt_operand_dispatcher.sv
module tb_sqrt_operand_dispatcher;
  localparam int DW = 32;
  localparam int RW = 16;
  localparam int MW = 17;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clk_en = 1'b1;
  always #5 clk = ~clk;

  sqrt_operand_dispatcher_if #(.DATA_WIDTH(DW)) bus ();
  sqrt_operand_dispatcher #(.DATA_WIDTH(DW), .FIFO_DEPTH(4)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .clk_en_i(clk_en), .bus(bus)
  );

  typedef struct {
    logic [RW-1:0] root;
    logic [MW-1:0] rem;
    logic [3:0]    tag;
  } res_t;

  res_t          exp_q[$];
  logic [DW-1:0] iss_q[$];
  int  n_cmp = 0, n_bad = 0, n_issued = 0;
  bit  stall = 1'b0, rnd_on = 1'b0;

  // Floor square root by binary search over the root range.
  function automatic res_t ref_sqrt(input logic [DW-1:0] v, input logic [3:0] t);
    res_t r;
    longint unsigned x, lo, hi, mid;
    x = 64'(v); lo = 0; hi = 65535;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= x) lo = mid; else hi = mid - 1;
    end
    r.root = RW'(lo);
    r.rem  = MW'(x - lo * lo);
    r.tag  = t;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Behavioural sqrt core: accepts an issue pulse, finishes after a random delay,
  // holds done until an enabled edge consumes it.
  initial begin : core_model
    bit en, iss, busy;
    int cnt;
    logic [DW-1:0] rad;
    res_t r;
    busy = 0; cnt = 0;
    bus.sqrt_done_i = 1'b0; bus.sqrt_root_i = '0; bus.sqrt_rem_i = '0;
    forever begin
      @(negedge clk);
      en = clk_en; iss = bus.sqrt_valid_o; rad = bus.sqrt_radicand_o;
      @(posedge clk); #1;
      if (!rst_n) begin
        busy = 0; bus.sqrt_done_i = 1'b0;
      end else if (en) begin
        if (bus.sqrt_done_i) bus.sqrt_done_i = 1'b0;
        if (iss) begin
          busy = 1; cnt = $urandom_range(0, 4);
        end else if (busy && !stall) begin
          if (cnt == 0) begin
            r = ref_sqrt(rad, 4'd0);
            bus.sqrt_root_i = r.root; bus.sqrt_rem_i = r.rem;
            bus.sqrt_done_i = 1'b1; busy = 0;
          end else cnt--;
        end
      end
    end
  end

  // Random enable / downstream back-pressure.
  initial forever begin
    @(posedge clk); #1;
    if (rnd_on) begin
      clk_en = ($urandom_range(0, 9) != 0);
      bus.result_ready_i = ($urandom_range(0, 2) != 0);
    end
  end

  // Issue monitor: each enabled issue pulse must carry the next accepted radicand.
  initial forever begin
    @(negedge clk);
    if (rst_n && bus.sqrt_valid_o && clk_en) begin
      n_issued++;
      if (iss_q.size() == 0) check("issue_unexpected", 64'(bus.sqrt_radicand_o), 64'hDEAD_0000_0000);
      else check("issue_radicand", 64'(bus.sqrt_radicand_o), 64'(iss_q.pop_front()));
    end
  end

  // Result monitor: compares accepted results and checks stability while stalled.
  initial begin : res_mon
    bit held;
    logic [RW-1:0] h_root;
    logic [MW-1:0] h_rem;
    res_t e;
    held = 0; h_root = '0; h_rem = '0;
    forever begin
      @(negedge clk);
      if (!rst_n || !bus.result_valid_o) held = 0;
      else begin
        if (held) begin
          check("hold_root", 64'(bus.root_o), 64'(h_root));
          check("hold_rem", 64'(bus.remainder_o), 64'(h_rem));
        end
        if (bus.result_ready_i && clk_en) begin
          held = 0;
          if (exp_q.size() == 0) check("result_unexpected", 64'(bus.root_o), 64'hDEAD_0000_0000);
          else begin
            e = exp_q.pop_front();
            check("root", 64'(bus.root_o), 64'(e.root));
            check("rem", 64'(bus.remainder_o), 64'(e.rem));
`ifdef SQRT_DISPATCH_TAG_EN
            check("tag", 64'(bus.tag_o), 64'(e.tag));
`endif
          end
        end else begin
          held = 1; h_root = bus.root_o; h_rem = bus.remainder_o;
        end
      end
    end
  end

  task automatic push(input logic [DW-1:0] v, input logic [3:0] t, output bit ok, input int max);
    ok = 0;
    bus.valid_i = 1'b1; bus.radicand_i = v;
`ifdef SQRT_DISPATCH_TAG_EN
    bus.tag_i = t;
`endif
    for (int i = 0; i < max && !ok; i++) begin
      @(negedge clk);
      if (bus.ready_o && clk_en && rst_n) begin
        ok = 1;
        exp_q.push_back(ref_sqrt(v, t));
        iss_q.push_back(v);
      end
      @(posedge clk); #2;
    end
    bus.valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (!bus.busy_o && exp_q.size() == 0) break;
    end
    check("drain_busy", 64'(bus.busy_o), 64'd0);
    check("drain_pending", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #2;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"}, 64'(bus.ready_o), 64'd1);
    check({tag, "_sqrt_valid"}, 64'(bus.sqrt_valid_o), 64'd0);
    check({tag, "_sqrt_rad"}, 64'(bus.sqrt_radicand_o), 64'd0);
    check({tag, "_res_valid"}, 64'(bus.result_valid_o), 64'd0);
    check({tag, "_root"}, 64'(bus.root_o), 64'd0);
    check({tag, "_rem"}, 64'(bus.remainder_o), 64'd0);
    check({tag, "_busy"}, 64'(bus.busy_o), 64'd0);
  endtask

  initial begin : stim
    bit ok;
    int base;
    logic [DW-1:0] v;
    bus.valid_i = 1'b0; bus.radicand_i = '0; bus.result_ready_i = 1'b1;
`ifdef SQRT_DISPATCH_TAG_EN
    bus.tag_i = '0;
`endif
    #12;
    check_reset_vals("reset");
    @(posedge clk); #2; rst_n = 1'b1;
    @(negedge clk);
    check_reset_vals("post_reset");
    @(posedge clk); #2;

    // Latency from acceptance to issue pulse on an idle, empty dispatcher.
    push(32'd144, 4'd1, ok, 10);
    check("push_144", 64'(ok), 64'd1);
    @(negedge clk); check("lat_cycle1", 64'(bus.sqrt_valid_o), 64'd0);
    @(negedge clk); check("lat_cycle2", 64'(bus.sqrt_valid_o), 64'd1);
    wait_idle();

    push(32'd150, 4'd2, ok, 10);
    push(32'hFFFF_FFFF, 4'd3, ok, 10);
    push(32'd0, 4'd4, ok, 10);
    push(32'd1, 4'd5, ok, 10);
    push(32'd16, 4'd3, ok, 10);
    push(32'd25, 4'd9, ok, 10);
    wait_idle();

    // Core stalled: one issued, four buffered, sixth rejected.
    stall = 1; base = n_issued;
    for (int k = 0; k < 5; k++) begin
      push(32'(1000 + k * 37), 4'(k), ok, 20);
      check("full_push_ok", 64'(ok), 64'd1);
    end
    @(negedge clk);
    check("full_ready", 64'(bus.ready_o), 64'd0);
    @(posedge clk); #2;
    push(32'd77, 4'd7, ok, 3);
    check("full_reject", 64'(ok), 64'd0);
    check("full_issued", 64'(n_issued - base), 64'd1);
    check("full_busy", 64'(bus.busy_o), 64'd1);
    stall = 0;
    wait_idle();

    // Downstream stalled: result held, no further issue.
    bus.result_ready_i = 1'b0; base = n_issued;
    for (int k = 0; k < 4; k++) push(32'(50000 + k * 999), 4'(k + 8), ok, 20);
    repeat (40) @(negedge clk);
    check("held_valid", 64'(bus.result_valid_o), 64'd1);
    check("held_issued", 64'(n_issued - base), 64'd1);
    @(posedge clk); #2; bus.result_ready_i = 1'b1;
    wait_idle();

    // Reset while waiting on the core.
    stall = 1; base = n_issued;
    push(32'd64, 4'd6, ok, 10);
    for (int i = 0; i < 20 && n_issued == base; i++) @(negedge clk);
    check("rst_issued", 64'(n_issued - base), 64'd1);
    repeat (2) @(negedge clk);
    @(posedge clk); #3; rst_n = 1'b0;
    #1;
    check_reset_vals("mid_wait_reset");
    exp_q.delete(); iss_q.delete();
    stall = 0;
    repeat (2) @(posedge clk);
    #2; rst_n = 1'b1;
    #1; check("rst_release_ready", 64'(bus.ready_o), 64'd1);
    @(posedge clk); #2;

    // Randomized traffic with random enable and back-pressure.
    rnd_on = 1;
    for (int n = 0; n < 150; n++) begin
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #2; end
      case ($urandom_range(0, 3))
        0: v = 32'($urandom_range(0, 300));
        1: v = 32'hFFFF_FFFF - 32'($urandom_range(0, 5));
        default: v = $urandom;
      endcase
      push(v, 4'($urandom_range(0, 15)), ok, 300);
      check("rnd_push_ok", 64'(ok), 64'd1);
    end
    rnd_on = 0;
    @(posedge clk); #2; clk_en = 1'b1; bus.result_ready_i = 1'b1;
    wait_idle();
    check("final_issue_q", 64'(iss_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
